// File: rtl/aximm_ram_responder.sv
// AXI4 slave backed by on-chip RAM: FIXED/INCR bursts with byte strobes,
// independent write and read engines, SLVERR on illegal or out-of-range beats.
module aximm_ram_responder #(
    parameter int unsigned   DW    = 512,
    parameter int unsigned   AW    = 64,
    parameter int unsigned   DEPTH = 1024,
    parameter logic [AW-1:0] BASE  = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [AW-1:0]     S_AXI_AWADDR,
    input  logic [7:0]        S_AXI_AWLEN,
    input  logic [2:0]        S_AXI_AWSIZE,
    input  logic [3:0]        S_AXI_AWID,
    input  logic [1:0]        S_AXI_AWBURST,
    input  logic              S_AXI_AWLOCK,
    input  logic [3:0]        S_AXI_AWCACHE,
    input  logic [3:0]        S_AXI_AWQOS,
    input  logic [2:0]        S_AXI_AWPROT,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [DW-1:0]     S_AXI_WDATA,
    input  logic [DW/8-1:0]   S_AXI_WSTRB,
    input  logic              S_AXI_WLAST,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic [3:0]        S_AXI_BID,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [AW-1:0]     S_AXI_ARADDR,
    input  logic [7:0]        S_AXI_ARLEN,
    input  logic [2:0]        S_AXI_ARSIZE,
    input  logic [3:0]        S_AXI_ARID,
    input  logic [1:0]        S_AXI_ARBURST,
    input  logic              S_AXI_ARLOCK,
    input  logic [3:0]        S_AXI_ARCACHE,
    input  logic [3:0]        S_AXI_ARQOS,
    input  logic [2:0]        S_AXI_ARPROT,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [DW-1:0]     S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic [3:0]        S_AXI_RID,
    output logic              S_AXI_RLAST,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY
);
    localparam int unsigned NB  = DW / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned IW  = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    function automatic logic hdr_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'(OFF)) || burst[1];
    endfunction

    function automatic logic beat_oor(input logic [AW-1:0] addr);
        logic [AW-1:0] rel;
        rel = addr - BASE;
        return (addr < BASE) || ((rel >> OFF) >= AW'(DEPTH));
    endfunction

    logic [DW-1:0] mem [DEPTH];
    logic          started;

    w_state_t      w_state, w_next;
    logic [AW-1:0] w_addr, w_beat_addr, w_rel;
    logic [7:0]    w_len;
    logic [3:0]    w_id;
    logic          w_incr, w_bad, w_err, w_beat_err, w_last_beat;
    logic [8:0]    w_cnt;
    logic [IW-1:0] w_idx;

    r_state_t      r_state, r_next;
    logic [AW-1:0] r_addr, r_beat_addr, r_rel;
    logic [7:0]    r_len;
    logic [3:0]    r_id;
    logic          r_incr, r_bad, r_err, r_beat_err, r_last_beat;
    logic [8:0]    r_cnt;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_word;

    // Handshakes are held off until the first edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) started <= 1'b0;
        else         started <= 1'b1;
    end

    // Beat address is recomputed from the burst start each beat, so range checks are per beat.
    always_comb begin
        w_beat_addr = w_addr + (w_incr ? (AW'(w_cnt) << OFF) : '0);
        w_rel       = w_beat_addr - BASE;
        w_idx       = w_rel[OFF +: IW];
        w_beat_err  = w_bad | beat_oor(w_beat_addr);
        w_last_beat = (w_cnt == {1'b0, w_len});
        r_beat_addr = r_addr + (r_incr ? (AW'(r_cnt) << OFF) : '0);
        r_rel       = r_beat_addr - BASE;
        r_idx       = r_rel[OFF +: IW];
        r_beat_err  = r_bad | beat_oor(r_beat_addr);
        r_last_beat = (r_cnt == {1'b0, r_len});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    always_comb begin
        w_next        = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = 2'b00;
        S_AXI_BID     = '0;
        case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = started;
                if (started && S_AXI_AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BID    = w_id;
                S_AXI_BRESP  = w_err ? 2'b10 : 2'b00;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_addr <= '0;
            w_len  <= '0;
            w_id   <= '0;
            w_incr <= 1'b0;
            w_bad  <= 1'b0;
            w_err  <= 1'b0;
            w_cnt  <= '0;
        end else if (w_state == W_IDLE && started && S_AXI_AWVALID) begin
            w_addr <= S_AXI_AWADDR;
            w_len  <= S_AXI_AWLEN;
            w_id   <= S_AXI_AWID;
            w_incr <= (S_AXI_AWBURST == 2'b01);
            w_bad  <= hdr_bad(S_AXI_AWSIZE, S_AXI_AWBURST);
            w_err  <= 1'b0;
            w_cnt  <= '0;
        end else if (w_state == W_DATA && S_AXI_WVALID) begin
            w_cnt <= w_cnt + 9'd1;
            if (w_beat_err || (S_AXI_WLAST != w_last_beat)) w_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    always_comb begin
        r_next        = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        S_AXI_RDATA   = '0;
        S_AXI_RRESP   = 2'b00;
        S_AXI_RID     = '0;
        S_AXI_RLAST   = 1'b0;
        case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = started;
                if (started && S_AXI_ARVALID) r_next = R_FETCH;
            end
            R_FETCH: r_next = R_DATA;
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                S_AXI_RDATA  = r_err ? '0 : r_word;
                S_AXI_RRESP  = r_err ? 2'b10 : 2'b00;
                S_AXI_RID    = r_id;
                S_AXI_RLAST  = r_last_beat;
                if (S_AXI_RREADY) r_next = r_last_beat ? R_IDLE : R_FETCH;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr <= '0;
            r_len  <= '0;
            r_id   <= '0;
            r_incr <= 1'b0;
            r_bad  <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == R_IDLE && started && S_AXI_ARVALID) begin
            r_addr <= S_AXI_ARADDR;
            r_len  <= S_AXI_ARLEN;
            r_id   <= S_AXI_ARID;
            r_incr <= (S_AXI_ARBURST == 2'b01);
            r_bad  <= hdr_bad(S_AXI_ARSIZE, S_AXI_ARBURST);
            r_cnt  <= '0;
        end else if (r_state == R_FETCH) begin
            r_err <= r_beat_err;
        end else if (r_state == R_DATA && S_AXI_RREADY && !r_last_beat) begin
            r_cnt <= r_cnt + 9'd1;
        end
    end

    // RAM has no reset; a read and write to the same word on one edge returns the old data.
    always_ff @(posedge clk) begin
        if (w_state == W_DATA && S_AXI_WVALID && !w_beat_err) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
        if (r_state == R_FETCH) r_word <= mem[r_idx];
    end
endmodule

// File: tb/tb_aximm_ram_responder.sv
// Randomised bench for aximm_ram_responder against a word-array memory model
// with per-beat address rules, plus directed cases with literal expectations.
module tb_aximm_ram_responder;
    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [3:0]  awid, arid, bid, rid;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;

    aximm_ram_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .resetn(resetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWID(awid),
        .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWQOS(4'd0),
        .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BID(bid), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARID(arid),
        .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARQOS(4'd0),
        .S_AXI_ARPROT(3'd0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RID(rid), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    typedef struct { logic [63:0] data; logic [1:0] resp; logic [3:0] id; logic last; } r_exp_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } b_exp_t;

    int total = 0;
    int bad = 0;
    logic [63:0] model_mem [DEPTH];
    r_exp_t      rq[$];
    b_exp_t      bq[$];
    logic [63:0] got_data[$];
    logic [1:0]  got_rresp[$];
    logic [1:0]  got_bresp[$];
    logic [3:0]  got_bid[$];
    logic [63:0] wd[$];
    logic [7:0]  ws[$];
    int rr_mode = 1;
    int br_mode = 1;
    bit mon_en = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void timeout(string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want handshake", name);
    endfunction

    function automatic bit hdr_ok(logic [2:0] size, logic [1:0] burst);
        return (size == 3'd3) && (burst == 2'b00 || burst == 2'b01);
    endfunction

    // Byte address of beat i, then RAM word index if it lands inside the RAM window.
    function automatic bit beat_idx(logic [31:0] a0, int i, logic [1:0] burst, output int unsigned idx);
        logic [31:0] a;
        a = a0 + ((burst == 2'b01) ? 32'(i * 8) : 32'd0);
        idx = 0;
        if (a < BASE) return 1'b0;
        idx = (a - BASE) >> 3;
        return idx < DEPTH;
    endfunction

    always @(negedge clk) begin
        case (rr_mode)
            0: rready = 1'b0;
            1: rready = 1'b1;
            default: rready = ($urandom_range(0, 2) != 0);
        endcase
        case (br_mode)
            0: bready = 1'b0;
            1: bready = 1'b1;
            default: bready = ($urandom_range(0, 2) != 0);
        endcase
    end

    always @(posedge clk) begin
        if (resetn && mon_en) begin
            if (rvalid && rready) begin
                got_data.push_back(rdata);
                got_rresp.push_back(rresp);
                if (rq.size() != 0) void'(rq.pop_front());
            end
            if (bvalid && bready) begin
                got_bresp.push_back(bresp);
                got_bid.push_back(bid);
                if (bq.size() != 0) void'(bq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && mon_en) begin
            if (rvalid) begin
                if (rq.size() == 0) chk("r_spurious", {63'd0, rvalid}, 64'd0);
                else begin
                    chk("rdata", rdata, rq[0].data);
                    chk("rresp", {62'd0, rresp}, {62'd0, rq[0].resp});
                    chk("rid", {60'd0, rid}, {60'd0, rq[0].id});
                    chk("rlast", {63'd0, rlast}, {63'd0, rq[0].last});
                end
            end
            if (bvalid) begin
                if (bq.size() == 0) chk("b_spurious", {63'd0, bvalid}, 64'd0);
                else begin
                    chk("bresp", {62'd0, bresp}, {62'd0, bq[0].resp});
                    chk("bid", {60'd0, bid}, {60'd0, bq[0].id});
                end
                chk("aw_blocked", {63'd0, awready}, 64'd0);
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int early, input int br_hold);
        bit err;
        bit wl;
        int unsigned idx;
        int n;
        b_exp_t e;
        err = !hdr_ok(size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            if (!beat_idx(addr, i, burst, idx) || !hdr_ok(size, burst)) err = 1'b1;
            else for (int b = 0; b < 8; b++) if (ws[i][b]) model_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
            wl = (early >= 0) ? (i == early) : (i == int'(len));
            if (wl != (i == int'(len))) err = 1'b1;
        end
        e.resp = err ? 2'b10 : 2'b00;
        e.id = id;
        bq.push_back(e);
        got_bresp.delete();
        got_bid.delete();
        br_mode = (br_hold > 0) ? 0 : 2;
        @(negedge clk);
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("aw_handshake");
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            wdata = wd[i]; wstrb = ws[i];
            wlast = (early >= 0) ? (i == early) : (i == int'(len));
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) timeout("w_handshake");
            @(posedge clk); @(negedge clk);
            wvalid = 1'b0; wlast = 1'b0;
        end
        if (br_hold > 0) begin
            n = 0;
            while (!bvalid && n < 50) begin @(negedge clk); n++; end
            repeat (br_hold) @(negedge clk);
            br_mode = 1;
        end
        n = 0;
        while (bq.size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) timeout("b_handshake");
        bq.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int hold);
        int unsigned idx;
        bit ok;
        int n;
        r_exp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            ok = beat_idx(addr, i, burst, idx) && hdr_ok(size, burst);
            e.data = ok ? model_mem[idx] : 64'd0;
            e.resp = ok ? 2'b00 : 2'b10;
            e.id = id;
            e.last = (i == int'(len));
            rq.push_back(e);
        end
        got_data.delete();
        got_rresp.delete();
        rr_mode = (hold > 0) ? 0 : 2;
        @(negedge clk);
        araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("ar_handshake");
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0;
        chk("lat_fetch", {63'd0, rvalid}, 64'd0);
        @(negedge clk);
        chk("lat_first", {63'd0, rvalid}, 64'd1);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            rr_mode = 1;
        end
        n = 0;
        while (rq.size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) timeout("r_handshake");
        rq.delete();
    endtask

    task automatic fill(input int n, input logic [63:0] first, input logic [63:0] step, input logic [7:0] strb);
        wd.delete();
        ws.delete();
        for (int i = 0; i < n; i++) begin
            wd.push_back(first + step * 64'(i));
            ws.push_back(strb);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_awready"}, {63'd0, awready}, 64'd0);
        chk({tag, "_arready"}, {63'd0, arready}, 64'd0);
        chk({tag, "_wready"}, {63'd0, wready}, 64'd0);
        chk({tag, "_bvalid"}, {63'd0, bvalid}, 64'd0);
        chk({tag, "_rvalid"}, {63'd0, rvalid}, 64'd0);
        chk({tag, "_rdata"}, rdata, 64'd0);
        chk({tag, "_rlast"}, {63'd0, rlast}, 64'd0);
        chk({tag, "_rid_resp"}, {58'd0, rid, rresp}, 64'd0);
        chk({tag, "_bid_resp"}, {58'd0, bid, bresp}, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        logic [1:0]  bu;
        logic [2:0]  sz;
        int r, early;
        awaddr = '0; awlen = '0; awsize = '0; awid = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arid = '0; arburst = '0; arvalid = 1'b0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #20;
        check_outputs_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        chk("awready_pre_edge", {63'd0, awready}, 64'd0);
        @(negedge clk);
        chk("awready_up", {63'd0, awready}, 64'd1);
        chk("arready_up", {63'd0, arready}, 64'd1);
        mon_en = 1'b1;

        fill(DEPTH, 64'h1111_0000_0000_0000, 64'h0000_0001_0000_0101, 8'hFF);
        do_write(BASE, 8'(DEPTH - 1), 3'd3, 2'b01, 4'd0, -1, 0);

        fill(4, 64'd1, 64'd1, 8'hFF);
        do_write(BASE + 32'h40, 8'd3, 3'd3, 2'b01, 4'd3, -1, 0);
        chk("t1_bresp", {62'd0, got_bresp[0]}, 64'd0);
        chk("t1_bid", {60'd0, got_bid[0]}, 64'd3);
        do_read(BASE + 32'h40, 8'd3, 3'd3, 2'b01, 4'd5, 0);
        chk("t1_nbeats", 64'(got_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t1_rdata", got_data[i], 64'(i + 1));

        fill(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'hFF);
        do_write(BASE, 8'd0, 3'd3, 2'b01, 4'd1, -1, 0);
        fill(1, 64'd0, 64'd0, 8'h0F);
        do_write(BASE, 8'd0, 3'd3, 2'b01, 4'd1, -1, 0);
        do_read(BASE, 8'd0, 3'd3, 2'b01, 4'd2, 0);
        chk("strb_word", got_data[0], 64'hFFFF_FFFF_0000_0000);

        fill(1, 64'hDEAD_BEEF_0BAD_F00D, 64'd0, 8'hFF);
        do_write(BASE + 32'h80, 8'd0, 3'd3, 2'b01, 4'd4, -1, 0);
        chk("oor_bresp", {62'd0, got_bresp[0]}, 64'd2);
        do_read(BASE + 32'h80, 8'd0, 3'd3, 2'b01, 4'd4, 0);
        chk("oor_rresp", {62'd0, got_rresp[0]}, 64'd2);
        chk("oor_rdata", got_data[0], 64'd0);
        do_read(BASE - 32'h8, 8'd0, 3'd3, 2'b01, 4'd4, 0);
        chk("below_rresp", {62'd0, got_rresp[0]}, 64'd2);
        fill(2, 64'h5555, 64'd1, 8'hFF);
        do_write(BASE + 32'h20, 8'd1, 3'd3, 2'b10, 4'd6, -1, 0);
        chk("wrap_bresp", {62'd0, got_bresp[0]}, 64'd2);
        fill(1, 64'h7777, 64'd0, 8'hFF);
        do_write(BASE + 32'h18, 8'd0, 3'd2, 2'b01, 4'd6, -1, 0);
        chk("size_bresp", {62'd0, got_bresp[0]}, 64'd2);

        fill(4, 64'hA, 64'd1, 8'hFF);
        do_write(BASE + 32'h28, 8'd3, 3'd3, 2'b00, 4'd7, -1, 0);
        do_read(BASE + 32'h28, 8'd1, 3'd3, 2'b01, 4'd7, 0);
        chk("fixed_word5", got_data[0], 64'hD);

        fill(4, 64'hC0, 64'd1, 8'hFF);
        do_write(BASE + 32'h70, 8'd3, 3'd3, 2'b01, 4'd8, -1, 0);
        chk("cross_bresp", {62'd0, got_bresp[0]}, 64'd2);
        do_read(BASE + 32'h70, 8'd3, 3'd3, 2'b01, 4'd8, 0);
        chk("cross_r0", {62'd0, got_rresp[0]}, 64'd0);
        chk("cross_r1", {62'd0, got_rresp[1]}, 64'd0);
        chk("cross_r2", {62'd0, got_rresp[2]}, 64'd2);
        chk("cross_r3", {62'd0, got_rresp[3]}, 64'd2);
        chk("cross_d1", got_data[1], 64'hC1);

        fill(3, 64'hE0, 64'd1, 8'hFF);
        do_write(BASE + 32'h10, 8'd2, 3'd3, 2'b01, 4'd9, 1, 0);
        chk("early_wlast_bresp", {62'd0, got_bresp[0]}, 64'd2);

        do_read(BASE + 32'h40, 8'd3, 3'd3, 2'b01, 4'd10, 5);
        fill(2, 64'h9000, 64'd1, 8'hFF);
        do_write(BASE + 32'h48, 8'd1, 3'd3, 2'b01, 4'd11, -1, 3);

        begin
            r_exp_t e;
            int unsigned idx;
            int n;
            for (int i = 0; i < 8; i++) begin
                void'(beat_idx(BASE, i, 2'b01, idx));
                e.data = model_mem[idx]; e.resp = 2'b00; e.id = 4'd12; e.last = (i == 7);
                rq.push_back(e);
            end
            rr_mode = 1;
            @(negedge clk);
            araddr = BASE; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arid = 4'd12; arvalid = 1'b1;
            @(posedge clk); @(negedge clk);
            arvalid = 1'b0;
            n = 0;
            while (rq.size() != 7 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) timeout("rst_beat1");
            @(negedge clk);
            chk("rst_beat2_valid", {63'd0, rvalid}, 64'd1);
            #2;
            mon_en = 1'b0;
            resetn = 1'b0;
            #1;
            check_outputs_zero("midreset");
            rq.delete();
            repeat (2) @(negedge clk);
            resetn = 1'b1;
            chk("rel_arready_pre", {63'd0, arready}, 64'd0);
            @(negedge clk);
            chk("rel_arready_up", {63'd0, arready}, 64'd1);
            mon_en = 1'b1;
        end
        do_read(BASE + 32'h8, 8'd2, 3'd3, 2'b01, 4'd13, 0);

        for (int t = 0; t < 150; t++) begin
            a = BASE - 32'h10 + 32'($urandom_range(0, DEPTH * 8 + 32));
            l = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 20)) : 8'($urandom_range(0, 4));
            r = $urandom_range(0, 9);
            bu = (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
            sz = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3;
            if ($urandom_range(0, 1) == 1) begin
                wd.delete();
                ws.delete();
                for (int i = 0; i <= int'(l); i++) begin
                    wd.push_back({$urandom, $urandom});
                    ws.push_back(8'($urandom));
                end
                early = (l > 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(l) - 1)) : -1;
                do_write(a, l, sz, bu, 4'($urandom), early, 0);
            end else begin
                do_read(a, l, sz, bu, 4'($urandom), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aximm_ram_responder.md
Name: aximm_ram_responder

Overview:
- AXI4 full-protocol slave (responder) backed by on-chip RAM.
- Terminates the AXI-MM master interface produced by the sliding-window translator, so window-translated PCIe/DMA traffic can be exercised and sniffed without external memory.
- Supports FIXED and INCR bursts with byte strobes and independent read and write engines.

Parameters:
- DW, 512, data width in bits; power of two, at least 32.
- AW, 64, address width.
- DEPTH, 1024, RAM depth in DW-wide words; power of two.
- BASE, 64'h0, byte address of RAM word 0.

Ports:
- clk  in  1  sole clock; all AXI signals sampled on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- S_AXI_AWADDR/AWLEN/AWSIZE/AWID/AWBURST  in  AW/8/3/4/2  write address; AWLOCK/AWCACHE/AWQOS/AWPROT accepted and ignored.
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in DW; S_AXI_WSTRB in DW/8; S_AXI_WLAST in 1; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BID out 4; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR/ARLEN/ARSIZE/ARID/ARBURST  in  AW/8/3/4/2  read address; ARLOCK/ARCACHE/ARQOS/ARPROT accepted and ignored.
- S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out DW; S_AXI_RRESP out 2; S_AXI_RID out 4; S_AXI_RLAST out 1; S_AXI_RVALID out 1; S_AXI_RREADY in 1.

Behaviour:
- Reset (resetn low, asynchronous): every output is 0. Both FSMs go to IDLE and any in-flight burst is dropped. RAM contents are preserved.
- AWREADY/ARREADY rise on the first clock edge after resetn deasserts.
- Address mapping: word index = (addr - BASE) >> log2(DW/8); low byte-offset bits are ignored.
- A beat is out of range if addr < BASE or word index >= DEPTH.
- A burst errors (SLVERR, 2'b10) if SIZE != log2(DW/8), if BURST is WRAP or reserved, or if any beat is out of range.
- Errored write beats are not written. Errored read beats return RDATA=0.
- Beat address advances by one word per beat for INCR and stays constant for FIXED.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake, latch addr/len/id/burst/size; AWREADY goes low next cycle; go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes RAM bytes where WSTRB=1 (if the beat is legal) and increments the beat count.
  - The burst ends after exactly AWLEN+1 beats regardless of WLAST. A WLAST mismatch (early or missing on the final beat) forces SLVERR. Go to W_RESP.
  - W_RESP: BVALID=1, BID=latched id, BRESP=OKAY (2'b00) or SLVERR. Hold until BREADY, then return to W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, latch fields; go to R_FETCH.
  - R_FETCH: issue the RAM read; 1-cycle RAM latency. Go to R_DATA.
  - R_DATA: RVALID=1 with RDATA/RRESP/RID stable. RLAST=1 on beat ARLEN.
  - On R handshake: if last beat go to R_IDLE, else go to R_FETCH.
  - Latency: first RVALID is 2 cycles after the AR handshake. Maximum throughput is one beat per 2 cycles.
- Reads and writes are fully concurrent. A same-word same-cycle collision is read-before-write: the read returns old data.
- RVALID/BVALID, once high, never drop until their handshake completes (except on reset).
- Beat counters are 9 bits wide, so the 256-beat maximum cannot wrap.
- INCR bursts crossing word DEPTH-1 make the crossing and all later beats SLVERR.

Test Plan:
- Write 4-beat INCR at BASE+0x40, WSTRB all 1s, data 1..4, AWID=3 -> BRESP=00, BID=3. Read same address, ARLEN=3, ARID=5 -> RDATA 1,2,3,4; RLAST only on beat 4; RID=5; RRESP=00.
- Fill word 0 with all 0xFF, then write 0x0 with WSTRB=0x...000F -> readback has low 4 bytes 0x00, all other bytes 0xFF.
- AWADDR=BASE+DEPTH*DW/8, len 0 -> BRESP=10 and RAM unchanged. Read of the same address -> RRESP=10, RDATA=0. A WRAP burst also -> SLVERR.
- FIXED write, AWLEN=3, to word 5 with data A,B,C,D -> word 5 reads D; word 6 is unchanged.
- Backpressure: RREADY low 5 cycles -> RVALID/RDATA/RLAST stable. BREADY low 3 cycles -> BVALID held and AWREADY=0 throughout.
- resetn pulsed low during beat 2 of an 8-beat read -> RVALID=0 immediately. After release, ARREADY=1 on the next edge and a fresh read returns correct data.
